// File: rtl/ps2_host_tx.sv
// ps2_host_tx: open-drain PS/2 host-to-device command byte transmitter with device ACK check
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN = 4
) (
  input  logic       Clock,
  input  logic       btnCpuReset,
  input  logic [7:0] TxData,
  input  logic       TxStart,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic       PS2ClkDriveLow,
  output logic       PS2DataDriveLow,
  output logic       TxBusy,
  output logic       TxDone,
  output logic       TxError,
  output logic       RxInhibit
);
  localparam int CW = $clog2(INHIBIT_CYCLES + TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, BITS, ACK, WAITIDLE} state_t;
  state_t state, state_n;
  logic [1:0] s1, s2;
  logic [FILTER_LEN-1:0] c_sh, d_sh;
  logic clk_f, dat_f, clk_f_d, fall, active;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0] data, data_n;
  logic [3:0] idx, idx_n;
  logic par, par_n, ack_ok, ack_ok_n;
  logic clk_low_n, dat_low_n, busy_n, done_n, err_n;
  always_ff @(posedge Clock or negedge btnCpuReset)
    if (!btnCpuReset) begin
      s1 <= '1;
      s2 <= '1;
      c_sh <= '1;
      d_sh <= '1;
      clk_f <= 1'b1;
      dat_f <= 1'b1;
      clk_f_d <= 1'b1;
    end else begin
      s1 <= {PS2Clk, PS2Data};
      s2 <= s1;
      c_sh <= {c_sh[FILTER_LEN-2:0], s2[1]};
      d_sh <= {d_sh[FILTER_LEN-2:0], s2[0]};
      clk_f <= &c_sh ? 1'b1 : ~|c_sh ? 1'b0 : clk_f;
      dat_f <= &d_sh ? 1'b1 : ~|d_sh ? 1'b0 : dat_f;
      clk_f_d <= clk_f;
    end
  assign fall = clk_f_d & ~clk_f;
  assign active = state inside {REQ, BITS, ACK, WAITIDLE};
  assign RxInhibit = TxBusy;
  always_comb begin
    state_n = state;
    cnt_n = (active && fall) ? '0 : cnt + CW'(1);
    data_n = data;
    par_n = par;
    ack_ok_n = ack_ok;
    idx_n = idx;
    clk_low_n = PS2ClkDriveLow;
    dat_low_n = PS2DataDriveLow;
    busy_n = TxBusy;
    done_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: if (TxStart) begin
        state_n = INHIBIT;
        cnt_n = '0;
        data_n = TxData;
        par_n = ~^TxData;
        idx_n = '0;
        busy_n = 1'b1;
        clk_low_n = 1'b1;
        dat_low_n = 1'b0;
      end
      INHIBIT: begin
        if (cnt == CW'(INHIBIT_CYCLES - 2)) dat_low_n = 1'b1;
        if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
          state_n = REQ;
          cnt_n = '0;
          clk_low_n = 1'b0;
        end
      end
      REQ: if (fall) begin
        state_n = BITS;
        dat_low_n = ~data[0];
        idx_n = 4'd1;
      end
      // idx 1..7 are data bits, 8 is parity, 9 releases the line for the stop bit
      BITS: if (fall) begin
        idx_n = idx + 4'd1;
        dat_low_n = idx == 4'd9 ? 1'b0 : idx == 4'd8 ? ~par : ~data[idx[2:0]];
        state_n = idx == 4'd9 ? ACK : BITS;
      end
      ACK: if (fall) begin
        state_n = WAITIDLE;
        ack_ok_n = ~dat_f;
      end
      WAITIDLE: if (clk_f && dat_f) begin
        state_n = IDLE;
        busy_n = 1'b0;
        done_n = ack_ok;
        err_n = ~ack_ok;
      end
      default: state_n = IDLE;
    endcase
    if (active && cnt == CW'(TIMEOUT_CYCLES - 1)) begin
      state_n = IDLE;
      busy_n = 1'b0;
      clk_low_n = 1'b0;
      dat_low_n = 1'b0;
      done_n = 1'b0;
      err_n = 1'b1;
    end
  end
  always_ff @(posedge Clock or negedge btnCpuReset)
    if (!btnCpuReset) begin
      state <= IDLE;
      cnt <= '0;
      data <= '0;
      idx <= '0;
      par <= 1'b0;
      ack_ok <= 1'b0;
      PS2ClkDriveLow <= 1'b0;
      PS2DataDriveLow <= 1'b0;
      TxBusy <= 1'b0;
      TxDone <= 1'b0;
      TxError <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      data <= data_n;
      idx <= idx_n;
      par <= par_n;
      ack_ok <= ack_ok_n;
      PS2ClkDriveLow <= clk_low_n;
      PS2DataDriveLow <= dat_low_n;
      TxBusy <= busy_n;
      TxDone <= done_n;
      TxError <= err_n;
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench with a PS/2 device model for ps2_host_tx
module tb_ps2_host_tx;
  localparam int INH = 50;
  localparam int TMO = 5000;
  localparam int HALF = 500;
  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       nack;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic tx_start = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic ps2_clk, ps2_dat, clk_drv, dat_drv, busy, done, err, rx_inh;
  int n_chk = 0;
  int n_fail = 0;
  int pulses = 0;
  logic exp_bits[$];
  logic [1:0] exp_out[$];
  vec_t vecs[3];
  assign ps2_clk = ~(clk_drv | dev_clk_low);
  assign ps2_dat = ~(dat_drv | dev_dat_low);
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(4)) dut (
    .Clock(clk), .btnCpuReset(rst_n), .TxData(tx_data), .TxStart(tx_start),
    .PS2Clk(ps2_clk), .PS2Data(ps2_dat), .PS2ClkDriveLow(clk_drv), .PS2DataDriveLow(dat_drv),
    .TxBusy(busy), .TxDone(done), .TxError(err), .RxInhibit(rx_inh));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  // every TxDone/TxError pulse is matched against the outcome queued at start
  always @(negedge clk)
    if (done || err) begin
      pulses++;
      if (exp_out.size() == 0) check("unexpected_pulse", {30'd0, done, err}, 32'd0);
      else check("outcome", {30'd0, done, err}, {30'd0, exp_out.pop_front()});
      check("busy_at_pulse", {31'd0, busy}, 32'd0);
    end
  task automatic push_bits(input logic [7:0] d, input logic par);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    exp_bits.push_back(par);
    exp_bits.push_back(1'b1);
  endtask
  task automatic start(input logic [7:0] d);
    tx_data = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("rxinhibit", {31'd0, rx_inh}, 32'd1);
    check("clk_inhibit", {31'd0, clk_drv}, 32'd1);
  endtask
  // device: waits for request, then 1000-cycle clocks, samples data on each rise
  task automatic dev_run(input logic nack, input int nfalls);
    int t = 0;
    while (!(ps2_clk && !ps2_dat) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("request_seen", {31'd0, t < 500}, 32'd1);
    repeat (200) @(negedge clk);
    for (int i = 1; i <= nfalls; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (i <= 10) begin
        if (exp_bits.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL bit%0d: got %0h, expected nothing", i, ps2_dat);
        end else check($sformatf("bit%0d", i), {31'd0, ps2_dat}, {31'd0, exp_bits.pop_front()});
      end
      dev_clk_low = 1'b0;
      if (i == 10) dev_dat_low = ~nack;
      if (i == 11) dev_dat_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
  endtask
  task automatic wait_pulse(input int p0);
    int t = 0;
    while (pulses == p0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("pulse_count", pulses - p0, 32'd1);
  endtask
  task automatic xfer(input logic [7:0] d, input logic par, input logic nack);
    int p0 = pulses;
    push_bits(d, par);
    exp_out.push_back(nack ? 2'b01 : 2'b10);
    start(d);
    dev_run(nack, 11);
    wait_pulse(p0);
    @(negedge clk);
    check("clk_released", {31'd0, clk_drv}, 32'd0);
    check("dat_released", {31'd0, dat_drv}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1);
  end
  initial begin
    int p0, n;
    vecs[0] = '{8'hED, 1'b1, 1'b0};
    vecs[1] = '{8'hF4, 1'b0, 1'b0};
    vecs[2] = '{8'h00, 1'b1, 1'b1};
    repeat (3) @(negedge clk);
    check("rst_clk_drv", {31'd0, clk_drv}, 32'd0);
    check("rst_dat_drv", {31'd0, dat_drv}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rxinh", {31'd0, rx_inh}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 0; i < 3; i++) xfer(vecs[i].data, vecs[i].par, vecs[i].nack);
    // silent device: inhibit length, start bit in last inhibit cycle, then timeout
    p0 = pulses;
    exp_out.push_back(2'b01);
    start(8'hA5);
    n = 0;
    while (clk_drv && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_cycles", n, INH);
    check("start_bit_low", {31'd0, dat_drv}, 32'd1);
    n = 0;
    while (!err && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, TMO);
    @(negedge clk);
    check("timeout_pulses", pulses - p0, 32'd1);
    check("timeout_clk_rel", {31'd0, clk_drv}, 32'd0);
    check("timeout_dat_rel", {31'd0, dat_drv}, 32'd0);
    check("timeout_busy", {31'd0, busy}, 32'd0);
    // start while busy ignored; start one cycle after TxDone accepted
    p0 = pulses;
    push_bits(8'hED, 1'b1);
    exp_out.push_back(2'b10);
    start(8'hED);
    fork
      dev_run(1'b0, 11);
      begin
        repeat (3000) @(negedge clk);
        tx_data = 8'h12;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        check("busy_ignore", {31'd0, busy}, 32'd1);
        n = 0;
        while (!done && n < 20000) begin
          @(negedge clk);
          n++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        @(negedge clk);
        push_bits(8'hED, 1'b1);
        start(8'hED);
      end
    join
    // reset while bit 4 (a zero) is on the line
    dev_run(1'b0, 5);
    check("bit4_driven", {31'd0, dat_drv}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_clk", {31'd0, clk_drv}, 32'd0);
    check("mid_rst_dat", {31'd0, dat_drv}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    exp_bits.delete();
    repeat (20) @(negedge clk);
    check("no_pulse_reset", pulses - p0, 32'd1);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    xfer(8'hED, 1'b1, 1'b0);
    check("queues_empty", exp_out.size() + exp_bits.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
